// File: rtl/sbox_sub_sched.sv
// rtl/sbox_sub_sched.sv - shared four-lane S-box engine serving state SubBytes and key SubWord requests
// One 32-bit operand per beat: a state job takes four column beats, a key job a single beat.

module sbox_lut (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] rev_idx;
  // Entry 0 sits in the top byte of the table, so index from the other end.
  assign rev_idx = 8'd255 - i_a;
  assign o_y = SBOX_TABLE[{rev_idx, 3'b000} +: 8];
endmodule

module sbox_sub_sched #(
  parameter int KEY_FIRST = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_st_valid,
  input  logic [127:0] i_st_data,
  output logic         o_st_ready,
  output logic         o_st_done,
  output logic [127:0] o_st_result,
  input  logic         i_kw_valid,
  input  logic [31:0]  i_kw_word,
  input  logic         i_kw_rot,
  output logic         o_kw_ready,
  output logic         o_kw_done,
  output logic [31:0]  o_kw_result,
  output logic         o_busy
);
  typedef enum logic [1:0] {IDLE, SUB, RESP} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         own_key_q, own_key_d;
  logic         prio_key_q, prio_key_d;
  logic [127:0] op_q, op_d;
  logic [127:0] st_res_q, st_res_d;
  logic [31:0]  kw_res_q, kw_res_d;
  logic         st_done_q, st_done_d;
  logic         kw_done_q, kw_done_d;
  logic [31:0]  lane_in, lane_out;
  logic         can_grant;

  assign can_grant  = (state_q == IDLE) && !i_rst;
  assign o_kw_ready = can_grant & i_kw_valid & (!i_st_valid | prio_key_q);
  assign o_st_ready = can_grant & i_st_valid & (!i_kw_valid | !prio_key_q);

  always_comb begin
    lane_in = op_q[31:0];
    if (!own_key_q) begin
      case (col_q)
        2'd0:    lane_in = op_q[127:96];
        2'd1:    lane_in = op_q[95:64];
        2'd2:    lane_in = op_q[63:32];
        default: lane_in = op_q[31:0];
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sbox_lut u_sbox (.i_a(lane_in[8*g +: 8]), .o_y(lane_out[8*g +: 8]));
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    own_key_d  = own_key_q;
    prio_key_d = prio_key_q;
    op_d       = op_q;
    st_res_d   = st_res_q;
    kw_res_d   = kw_res_q;
    st_done_d  = 1'b0;
    kw_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (o_kw_ready) begin
          op_d       = {96'd0, i_kw_rot ? {i_kw_word[23:0], i_kw_word[31:24]} : i_kw_word};
          own_key_d  = 1'b1;
          prio_key_d = 1'b0;
          col_d      = 2'd0;
          state_d    = SUB;
        end else if (o_st_ready) begin
          op_d       = i_st_data;
          own_key_d  = 1'b0;
          prio_key_d = 1'b1;
          col_d      = 2'd0;
          state_d    = SUB;
        end
      end
      SUB: begin
        if (own_key_q) begin
          kw_res_d  = lane_out;
          kw_done_d = 1'b1;
          state_d   = RESP;
        end else begin
          // Substituted columns overwrite the consumed operand so the visible result changes only once.
          case (col_q)
            2'd0:    op_d[127:96] = lane_out;
            2'd1:    op_d[95:64]  = lane_out;
            2'd2:    op_d[63:32]  = lane_out;
            default: begin
              st_res_d  = {op_q[127:32], lane_out};
              st_done_d = 1'b1;
              state_d   = RESP;
            end
          endcase
          col_d = col_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      col_q      <= 2'd0;
      own_key_q  <= 1'b0;
      prio_key_q <= (KEY_FIRST != 0);
      op_q       <= 128'd0;
      st_res_q   <= 128'd0;
      kw_res_q   <= 32'd0;
      st_done_q  <= 1'b0;
      kw_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      own_key_q  <= own_key_d;
      prio_key_q <= prio_key_d;
      op_q       <= op_d;
      st_res_q   <= st_res_d;
      kw_res_q   <= kw_res_d;
      st_done_q  <= st_done_d;
      kw_done_q  <= kw_done_d;
    end
  end

  assign o_st_done   = st_done_q;
  assign o_kw_done   = kw_done_q;
  assign o_st_result = st_res_q;
  assign o_kw_result = kw_res_q;
  assign o_busy      = (state_q != IDLE);
endmodule

// File: doc/sbox_sub_sched.md
# sbox_sub_sched

Time-multiplexed SubBytes/SubWord engine that shares one bank of four SBOX lookup instances between two requesters: the round datapath (128-bit state SubBytes) and the key-expansion unit (32-bit SubWord, optional RotWord). It sits between the AES round controller and key scheduler. It arbitrates round-robin, sequences the state one 32-bit column per cycle, and returns registered results with a one-cycle done pulse per requester.

## Interface
- KEY_FIRST, default 1: arbitration priority after reset. 1 = key port wins the first tie; 0 = state port wins.
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_st_valid  in  1  state request valid; held until accepted.
- i_st_data  in  128  state to substitute; byte 15 = bits [127:120].
- o_st_ready  out  1  state request accepted this cycle when high together with i_st_valid.
- o_st_done  out  1  one-cycle pulse; o_st_result valid.
- o_st_result  out  128  SubBytes(i_st_data); held until the next state completion.
- i_kw_valid  in  1  key-word request valid.
- i_kw_word  in  32  word to substitute.
- i_kw_rot  in  1  apply RotWord (rotate left 8) before SubWord; sampled with the request.
- o_kw_ready  out  1  key request accepted.
- o_kw_done  out  1  one-cycle pulse; o_kw_result valid.
- o_kw_result  out  32  result; held until the next key completion.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- Instantiates exactly four SBOX lookups. Lane n maps bits [8n+7:8n] of the current 32-bit operand. No other S-box logic is allowed.
- The FSM has three states: IDLE, SUB and RESP.
- IDLE: readies are combinational.
  - o_kw_ready = IDLE & i_kw_valid & (!i_st_valid | prio_key).
  - o_st_ready = IDLE & i_st_valid & (!i_kw_valid | !prio_key).
  - At most one handshake per cycle.
  - On handshake, capture the operand, record the owner, and go to SUB with column counter = 0.
  - For the key port, the captured operand is {w[23:0], w[31:24]} if i_kw_rot, else w.
- prio_key toggles on every handshake. After the last grant it points to the other port. Its reset value is KEY_FIRST.
- SUB, state owner: column c (0..3) processes bits [127-32c -: 32] of the captured state. The lane outputs are written into the same slice of the result register. After c = 3, go to RESP.
- SUB, key owner: a single beat writes o_kw_result, then go to RESP.
- RESP: assert the owner's done for exactly one cycle, then return to IDLE. Readies are low in SUB and RESP.
- Input changes after the handshake have no effect on the job in flight.
- A valid that is not accepted must be held by the requester. The block does not latch pending requests.

## Timing
- Acceptance edge E0.
  - State job: columns written at edges E1..E4; o_st_done high in the cycle after E4. That is 5 cycles of latency and 6 cycles per job, including IDLE.
  - Key job: result written at E1; o_kw_done high in the cycle after E1. That is 2 cycles of latency and 3 cycles per job.
- o_*_result updates only on the owner's completion. It is stable during and after the done pulse.
- When both ports are valid continuously, grants alternate between them, with the first grant going to the KEY_FIRST port.
- Reset values:
  - o_st_ready = 0, o_kw_ready = 0, o_st_done = 0, o_kw_done = 0, o_busy = 0.
  - o_st_result = 0, o_kw_result = 0.
  - State = IDLE, column counter = 0, prio_key = KEY_FIRST.
- Reset mid-job (SUB or RESP): the job is abandoned and no done pulse is issued. Results clear to 0. Readies may rise in the first cycle after reset is released.
- A valid asserted during reset is accepted only after reset deasserts.

## Test plan
- State job:
  - Stimulus: i_st_data = 00112233445566778899aabbccddeeff.
  - Required response: o_st_result = 638293c31bfc33f5c4eeacea4bc12816, o_st_done exactly 5 cycles after acceptance, o_busy high for 5 cycles.
- Key job with rotation:
  - Stimulus: i_kw_word = 09cf4f3c, i_kw_rot = 1.
  - Required response: o_kw_result = 8a84eb01, done 2 cycles after acceptance.
  - Repeat with i_kw_rot = 0: required o_kw_result = 018a84eb.
- Simultaneous requests after reset with KEY_FIRST = 1:
  - Stimulus: both ports valid.
  - Required response: key accepted first. The state request is accepted on the first IDLE cycle after the key job completes (3 cycles later). Grants then alternate over 4 further back-to-back requests.
- Reset mid-job:
  - Stimulus: assert i_rst during column 2 of a state job.
  - Required response: no o_st_done, o_st_result = 0, o_busy = 0 the cycle after reset. A new request after reset completes correctly.
- Stability:
  - Stimulus: change i_st_data to ffffffffffffffffffffffffffffffff on the cycle after acceptance of 00..00.
  - Required response: o_st_result = 63636363636363636363636363636363.
  - o_st_result must hold unchanged through a subsequent key job.
- Exhaustive lanes:
  - Stimulus: 64 key jobs covering all 256 byte values across the lanes (i_kw_rot = 0).
  - Required response: every byte of each o_kw_result matches the FIPS-197 S-box.
